// File: rtl/softmax_row_loader_if.sv
// Row-loader bus: memory read port, assembled row and consumer handshake.
// o_row_max exists only when ROW_LOADER_MAX_EN is defined.
interface softmax_row_loader_if #(
    parameter int N      = 32,
    parameter int DW     = 16,
    parameter int ADDR_W = 10
);
    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DW-1:0]     i_rd_data;
    logic [DW-1:0]     o_row [N-1:0];
    logic              o_valid;
    logic              i_ack;
    logic              o_busy;
`ifdef ROW_LOADER_MAX_EN
    logic [DW-1:0]     o_row_max;
`endif

    modport master (
        input  i_start,
        input  i_base,
        input  i_rd_data,
        input  i_ack,
        output o_rd_en,
        output o_rd_addr,
        output o_row,
        output o_valid,
        output o_busy
`ifdef ROW_LOADER_MAX_EN
        , output o_row_max
`endif
    );

    modport slave (
        output i_start,
        output i_base,
        output i_rd_data,
        output i_ack,
        input  o_rd_en,
        input  o_rd_addr,
        input  o_row,
        input  o_valid,
        input  o_busy
`ifdef ROW_LOADER_MAX_EN
        , input o_row_max
`endif
    );
endinterface

// File: rtl/softmax_row_loader.sv
// Loads an N-element row from a synchronous-read memory into a parallel array.
// Defining ROW_LOADER_MAX_EN adds a running signed row maximum (o_row_max).
module softmax_row_loader #(
    parameter int N      = 32,
    parameter int DW     = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    softmax_row_loader_if.master bus
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     iss_q, iss_d;
    logic [CW-1:0]     cap_q, cap_d;
    logic [RD_LAT:1]   tag_q;
    logic [DW-1:0]     row_q [N-1:0];
    logic              rd_en;
    logic              tag;
    logic              ack_hs;
    logic              load;

    assign rd_en  = (state_q == S_ISSUE);
    assign tag    = tag_q[RD_LAT];
    assign ack_hs = (state_q == S_HOLD) && bus.i_ack;
    // a start together with the ack in HOLD reloads with no idle bubble
    assign load   = bus.i_start && ((state_q == S_IDLE) || ack_hs);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = S_ISSUE;
            S_ISSUE: if (iss_q == CW'(N-1)) state_d = S_DRAIN;
            S_DRAIN: if (tag && cap_q == CW'(N-1)) state_d = S_HOLD;
            S_HOLD:  if (ack_hs) state_d = load ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d = load ? bus.i_base : base_q;
        iss_d  = load ? '0 : (rd_en ? iss_q + 1'b1 : iss_q);
        cap_d  = load ? '0 : (tag ? cap_q + 1'b1 : cap_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            iss_q   <= '0;
            cap_q   <= '0;
            tag_q   <= '0;
            for (int k = 0; k < N; k++) row_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            iss_q    <= iss_d;
            cap_q    <= cap_d;
            // tag pipe mirrors the memory latency so data lands with its slot
            tag_q[1] <= rd_en;
            for (int i = 2; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (tag) row_q[cap_q] <= bus.i_rd_data;
        end
    end

`ifdef ROW_LOADER_MAX_EN
    logic [DW-1:0] max_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_q <= '0;
        end else if (tag && (cap_q == '0 ||
                     $signed(bus.i_rd_data) > $signed(max_q))) begin
            max_q <= bus.i_rd_data;
        end
    end

    assign bus.o_row_max = max_q;
`endif

    assign bus.o_rd_en   = rd_en;
    assign bus.o_rd_addr = rd_en ? base_q + ADDR_W'(iss_q) : '0;
    assign bus.o_valid   = (state_q == S_HOLD);
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_row     = row_q;
endmodule

// File: tb/tb_softmax_row_loader.sv
// Bench for softmax_row_loader: memory model, event-level reference model,
// per-cycle compare plus directed and randomized loads.
module tb_softmax_row_loader;
    localparam int N      = 32;
    localparam int DW     = 16;
    localparam int AW     = 10;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softmax_row_loader_if #(.N(N), .DW(DW), .ADDR_W(AW)) ifc ();

    softmax_row_loader #(.N(N), .DW(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc)
    );

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd_pipe [RD_LAT];

    // memory returns junk when not reading so misaligned capture shows up
    always @(posedge clk) begin
        rd_pipe[0] <= ifc.o_rd_en ? mem[ifc.o_rd_addr] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ifc.i_rd_data = rd_pipe[RD_LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;

    logic          act_m;
    logic          val_m;
    int            t0_m;
    logic [AW-1:0] base_m;
    logic [DW-1:0] row_m [N];
    logic [DW-1:0] max_m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: a load accepted at edge t reads base+k after edge t+k and
    // presents the row after edge t+N+RD_LAT until the acknowledging edge.
    task automatic model_edge();
        logic acc;
        if (rst) begin
            act_m = 1'b0;
            val_m = 1'b0;
            max_m = '0;
            for (int k = 0; k < N; k++) row_m[k] = '0;
        end else begin
            acc = ifc.i_start && ((!act_m && !val_m) || (val_m && ifc.i_ack));
            if (val_m && ifc.i_ack) val_m = 1'b0;
            if (act_m && cyc - t0_m == N + RD_LAT) begin
                act_m = 1'b0;
                val_m = 1'b1;
                for (int k = 0; k < N; k++) row_m[k] = mem[AW'(int'(base_m) + k)];
                max_m = row_m[0];
                for (int k = 1; k < N; k++)
                    if ($signed(row_m[k]) > $signed(max_m)) max_m = row_m[k];
            end
            if (acc) begin
                act_m  = 1'b1;
                t0_m   = cyc;
                base_m = ifc.i_base;
            end
        end
    endtask

    task automatic compare();
        logic          e_en;
        logic [AW-1:0] e_addr;
        int            bad;
        e_en   = !rst && act_m && (cyc - t0_m) < N;
        e_addr = e_en ? AW'(int'(base_m) + cyc - t0_m) : '0;
        chk("ctl{rd_en,valid,busy}",
            {29'd0, ifc.o_rd_en, ifc.o_valid, ifc.o_busy},
            {29'd0, e_en, !rst && val_m, !rst && (act_m || val_m)});
        if (e_en || rst) chk("rd_addr", {22'd0, ifc.o_rd_addr}, {22'd0, e_addr});
        if (val_m || rst) begin
            bad = -1;
            for (int k = 0; k < N; k++)
                if (bad < 0 && ifc.o_row[k] !== (rst ? '0 : row_m[k])) bad = k;
            n_cmp++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL row[%0d]: got %h want %h @cyc %0d", bad,
                         ifc.o_row[bad], rst ? '0 : row_m[bad], cyc);
            end
`ifdef ROW_LOADER_MAX_EN
            chk("row_max", {16'd0, ifc.o_row_max}, {16'd0, rst ? '0 : max_m});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
        if (ifc.o_rd_en) rd_cnt++;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 200 && !ifc.o_valid; i++) tick();
        if (!ifc.o_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: valid 0 want 1 @cyc %0d", nm, cyc);
        end
    endtask

    task automatic start_load(input logic [AW-1:0] b, output int ts);
        ifc.i_base  = b;
        ifc.i_start = 1'b1;
        tick();
        ts = cyc;
        ifc.i_start = 1'b0;
        ifc.i_base  = AW'($urandom);
    endtask

    task automatic ack_row();
        ifc.i_ack = 1'b1;
        tick();
        ifc.i_ack = 1'b0;
    endtask

    initial begin
        int            ts;
        logic [AW-1:0] ad [5];
        logic          b2b;
        act_m = 1'b0;
        val_m = 1'b0;
        t0_m  = 0;
        base_m = '0;
        max_m = '0;
        for (int k = 0; k < N; k++) row_m[k] = '0;
        for (int a = 0; a < 1024; a++) mem[a] = DW'(a);
        ifc.i_start = 1'b0;
        ifc.i_base  = '0;
        ifc.i_ack   = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", {31'd0, ifc.o_busy}, 32'd0);
        rst = 1'b0;
        tick();

        // basic load, identity memory
        rd_cnt = 0;
        start_load(10'd0, ts);
        wait_valid("t1");
        chk("t1_latency", cyc - ts + 1, 32'd34);
        chk("t1_rd_cycles", rd_cnt, 32'd32);
        chk("t1_row5", {16'd0, ifc.o_row[5]}, 32'd5);
        chk("t1_row31", {16'd0, ifc.o_row[31]}, 32'd31);
        ack_row();
        chk("t1_valid_after_ack", {31'd0, ifc.o_valid}, 32'd0);

        // wrap past top of memory
        for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
        start_load(10'd1020, ts);
        for (int i = 0; i < 5; i++) begin
            ad[i] = ifc.o_rd_addr;
            tick();
        end
        chk("t2_addr0", {22'd0, ad[0]}, 32'd1020);
        chk("t2_addr3", {22'd0, ad[3]}, 32'd1023);
        chk("t2_addr4", {22'd0, ad[4]}, 32'd0);
        wait_valid("t2");
        chk("t2_row4", {16'd0, ifc.o_row[4]}, {16'd0, mem[0]});

        // hold with ack low, start pulses ignored
        for (int i = 0; i < 10; i++) begin
            ifc.i_start = 1'($urandom);
            ifc.i_base  = AW'($urandom);
            tick();
        end
        ifc.i_start = 1'b0;
        chk("t3_still_valid", {31'd0, ifc.o_valid}, 32'd1);
        ack_row();
        chk("t3_valid_low", {31'd0, ifc.o_valid}, 32'd0);
        chk("t3_busy_low", {31'd0, ifc.o_busy}, 32'd0);

        // back-to-back load
        start_load(10'd300, ts);
        wait_valid("t4a");
        ifc.i_ack   = 1'b1;
        ifc.i_start = 1'b1;
        ifc.i_base  = 10'd64;
        tick();
        ts = cyc;
        ifc.i_ack   = 1'b0;
        ifc.i_start = 1'b0;
        chk("t4_rd_en", {31'd0, ifc.o_rd_en}, 32'd1);
        chk("t4_addr", {22'd0, ifc.o_rd_addr}, 32'd64);
        wait_valid("t4b");
        chk("t4_latency", cyc - ts + 1, 32'd34);
        ack_row();

        // reset in the middle of issue
        start_load(10'd500, ts);
        repeat (10) tick();
        chk("t5_addr_k10", {22'd0, ifc.o_rd_addr}, 32'd510);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        start_load(10'd200, ts);
        wait_valid("t5");
        chk("t5_row0", {16'd0, ifc.o_row[0]}, {16'd0, mem[200]});
        chk("t5_row31", {16'd0, ifc.o_row[31]}, {16'd0, mem[231]});
        ack_row();

`ifdef ROW_LOADER_MAX_EN
        for (int k = 0; k < N; k++)
            mem[600+k] = (k == 17) ? 16'h7FFF : (k == 0 ? 16'hFFFB : 16'h8000);
        start_load(10'd600, ts);
        wait_valid("t6a");
        chk("t6_max_pos", {16'd0, ifc.o_row_max}, 32'h7FFF);
        ack_row();
        for (int k = 0; k < N; k++) mem[600+k] = 16'h8000;
        start_load(10'd600, ts);
        wait_valid("t6b");
        chk("t6_max_neg", {16'd0, ifc.o_row_max}, 32'h8000);
        ack_row();
`endif

        // randomized loads with handshake noise
        b2b = 1'b0;
        for (int it = 0; it < 14; it++) begin
            if (!b2b) begin
                repeat ($urandom_range(0, 3)) begin
                    ifc.i_ack = 1'($urandom);
                    tick();
                end
                ifc.i_ack = 1'b0;
                for (int k = 0; k < 16; k++) mem[$urandom_range(0, 1023)] = DW'($urandom);
                start_load(AW'($urandom), ts);
            end
            for (int i = 0; i < 200 && !ifc.o_valid; i++) begin
                ifc.i_start = ($urandom_range(0, 3) == 0);
                ifc.i_ack   = 1'($urandom);
                ifc.i_base  = AW'($urandom);
                tick();
            end
            ifc.i_start = 1'b0;
            ifc.i_ack   = 1'b0;
            if (!ifc.o_valid) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_valid timeout it %0d: valid 0 want 1", it);
            end
            repeat ($urandom_range(0, 4)) begin
                ifc.i_start = 1'($urandom);
                tick();
            end
            b2b = 1'($urandom);
            ifc.i_ack   = 1'b1;
            ifc.i_start = b2b;
            ifc.i_base  = AW'($urandom);
            tick();
            ifc.i_ack   = 1'b0;
            ifc.i_start = 1'b0;
        end
        ifc.i_ack = 1'b1;
        for (int i = 0; i < 200 && ifc.o_busy; i++) tick();
        ifc.i_ack = 1'b0;
        chk("final_idle", {31'd0, ifc.o_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
